stc0_egress_serializer: RTL and testbench
=========================================

# stc0_egress_serializer

Buffered word-to-byte egress stage for the stc0 core. It sits directly downstream of the egress stage and consumes its 32-bit `{real[15:0], imag[15:0]}` result words through a valid/ready handshake. It stores the words in a small FIFO and drives them onto the 8-bit output pins one byte per cycle, MSB first. Downstream backpressure (`Hold`) stalls the byte stream without losing data. FIFO overrun is reported through a sticky flag.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in 32-bit words; must be a power of two, ≥ 2.
- `DEPTH_LOG2`, 2: log2(`DEPTH`).

Ports:
- `Clk`  in  1: single clock; all logic is on the rising edge.
- `ARstn`  in  1: reset, asynchronous, active-low. Assertion is asynchronous; deassertion is synchronous to `Clk` and handled upstream.
- `WriteData`  in  32: result word from the egress stage.
- `WriteDataValid`  in  1: `WriteData` is valid this cycle.
- `Ready`  out  1: FIFO can accept a word this cycle.
- `Hold`  in  1: downstream stall request; no byte is issued in a cycle where it is high.
- `Data`  out  8: output byte (registered).
- `DataValid`  out  1: `Data` is valid this cycle (registered).
- `Level`  out  DEPTH_LOG2+1: current FIFO occupancy in words.
- `Overflow`  out  1: sticky; set when a word is dropped.

## Operation
- Reset values: `Data`=0x00, `DataValid`=0, `Level`=0, `Overflow`=0, `Ready`=1. FIFO pointers are 0. Shift register and byte counter are 0. FSM is in IDLE.
- `Ready` = (`Level` != `DEPTH`). It is combinational from registered `Level` only. It does not anticipate a same-cycle pop.
- Push: a word is pushed when `WriteDataValid` && `Ready`. The write pointer then increments modulo `DEPTH`.
- Drop: when `WriteDataValid` && !`Ready`, the word is discarded and `Overflow` is set to 1. `Overflow` stays at 1 until reset.
- Simultaneous push and pop: `Level` is unchanged and both pointers advance.
- FSM states: IDLE and SHIFT. The byte counter `bc` is 2 bits and counts bytes already issued from the current word.
- IDLE:
  - If `Level`≠0 and !`Hold`: pop the head word into `sr`, `Data`←word[31:24], `DataValid`←1, `bc`←1, go to SHIFT.
  - Otherwise `DataValid`←0.
- SHIFT with `Hold`=1: `DataValid`←0. `Data`, `sr` and `bc` keep their values.
- SHIFT with `Hold`=0 and `bc`∈{1,2,3}:
  - `Data`←`sr` byte (3-`bc`), so the order is [31:24], [23:16], [15:8], [7:0].
  - `DataValid`←1 and `bc`←`bc`+1.
- End of word (`bc`=3 with `Hold`=0, i.e. the last byte is being issued):
  - If `Level`≠0 after accounting for this cycle's registered state, the next word is popped in the following cycle. The FSM stays in SHIFT and moves to `bc`=0 of the new word with no bubble.
  - Otherwise the FSM goes to IDLE.
  - Implement this as follows: on the last byte, set the state to LOAD-pending. In the next cycle, with !`Hold` and `Level`≠0, pop and issue byte [31:24] directly, exactly as in IDLE.
- Net effect: consecutive words produce a gap-free byte stream.
- Bytes issued while `Hold`=0 are never repeated. A byte is never skipped.
- Reset mid-operation: all state returns to reset values immediately. Any partially sent word and all buffered words are discarded.

## Timing
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE and `Hold`=0 gives `DataValid`=1 with byte [31:24] after edge N+1. The remaining bytes follow after edges N+2, N+3 and N+4.
- Throughput: 1 byte per cycle, or 1 word per 4 cycles, sustained.
- A `Hold` sampled high at edge k gives `DataValid`=0 after edge k.
- `Level` updates on the edge of the push or pop.
- Full boundary: `Ready` falls in the cycle after the push that makes `Level`=`DEPTH`. It rises in the cycle after the first pop.
- Empty boundary: with `Level`=0 at the end of a word, `DataValid`=0 from the next cycle onward.

## Test plan
- Reset: hold `ARstn`=0 for 3 cycles, then release → `Data`=0x00, `DataValid`=0, `Level`=0, `Overflow`=0, `Ready`=1.
- Single word: push 0xDEADBEEF at edge N → `DataValid`=1 after edges N+1 through N+4 with `Data` = DE, AD, BE, EF; `DataValid`=0 after N+5; `Level` returns to 0.
- Back-to-back: push 0x01234567 and 0x89ABCDEF on consecutive cycles → 8 consecutive valid bytes 01 23 45 67 89 AB CD EF with no gap.
- Stall: push 0xDEADBEEF and raise `Hold` for 3 cycles after byte AD → `DataValid`=0 for exactly 3 cycles, then BE, EF; no byte duplicated.
- Overflow with `DEPTH`=4: with `Hold`=1, push 5 words 0x0..0x4 → `Ready`=0 after the 4th push, `Level`=4, 5th word dropped, `Overflow`=1. Release `Hold` → 16 bytes for words 0–3 only; `Overflow` stays 1.
- Reset mid-word: drop `ARstn` after byte 2 of a word with 2 more words queued → outputs go to reset values immediately; after release there are no bytes and `Level`=0.

Source files
------------

// File: rtl/stc0_egress_serializer_if.sv
// rtl/stc0_egress_serializer_if.sv - word-in / byte-out bus of the stc0 egress serializer
interface stc0_egress_serializer_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic [31:0]         WriteData;
    logic                WriteDataValid;
    logic                Ready;
    logic                Hold;
    logic [7:0]          Data;
    logic                DataValid;
    logic [DEPTH_LOG2:0] Level;
    logic                Overflow;

    modport master (
        output WriteData, WriteDataValid, Hold,
        input  Ready, Data, DataValid, Level, Overflow
    );

    modport slave (
        input  WriteData, WriteDataValid, Hold,
        output Ready, Data, DataValid, Level, Overflow
    );
endinterface

// File: rtl/stc0_egress_serializer.sv
// rtl/stc0_egress_serializer.sv - buffered 32-bit word to 8-bit byte egress serializer
module stc0_egress_serializer #(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                     Clk,
    input  logic                     ARstn,
    stc0_egress_serializer_if.slave  bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic [31:0]           sr;
    logic [1:0]            bc;
    logic [0:0]            state;
    logic [7:0]            data_q;
    logic                  data_valid_q;
    logic                  ready;
    logic                  push;
    logic                  pop;
    logic                  load_slot;
    logic [7:0]            next_byte;

    assign ready = (level != FULL);
    assign push  = bus.WriteDataValid && ready;

    // bc==0 inside SHIFT is the load-pending slot after a word's last byte;
    // it pops exactly like IDLE so consecutive words stream without a bubble.
    assign load_slot = (state == S_IDLE) || (bc == 2'd0);
    assign pop       = load_slot && !bus.Hold && (level != '0);

    always_comb begin
        next_byte = sr[7:0];
        case (bc)
            2'd1:    next_byte = sr[23:16];
            2'd2:    next_byte = sr[15:8];
            default: next_byte = sr[7:0];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.WriteData;
        end
    end

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (bus.WriteDataValid && !ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            state        <= S_IDLE;
            sr           <= '0;
            bc           <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else if (pop) begin
            sr           <= mem[rd_ptr];
            data_q       <= mem[rd_ptr][31:24];
            data_valid_q <= 1'b1;
            bc           <= 2'd1;
            state        <= S_SHIFT;
        end else if (load_slot) begin
            data_valid_q <= 1'b0;
            if (level == '0) begin
                state <= S_IDLE;
            end
        end else if (bus.Hold) begin
            data_valid_q <= 1'b0;
        end else begin
            data_q       <= next_byte;
            data_valid_q <= 1'b1;
            bc           <= bc + 2'd1;
        end
    end

    assign bus.Ready     = ready;
    assign bus.Data      = data_q;
    assign bus.DataValid = data_valid_q;
    assign bus.Level     = level;
    assign bus.Overflow  = overflow;
endmodule

// File: tb/tb_stc0_egress_serializer.sv
// tb/tb_stc0_egress_serializer.sv - randomized and directed bench for stc0_egress_serializer
module tb_stc0_egress_serializer;
    localparam int DEPTH      = 4;
    localparam int DEPTH_LOG2 = 2;

    logic Clk   = 1'b0;
    logic ARstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    stc0_egress_serializer_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    stc0_egress_serializer #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .Clk   (Clk),
        .ARstn (ARstn),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [31:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    logic [7:0]  m_data;
    logic        m_dv;
    logic        m_ovf;
    logic [7:0]  got[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cur.delete();
        m_data = 8'h00;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One clock: the model sees the same inputs at the word/byte level,
    // popping on the pre-edge occupancy and pushing afterwards.
    task automatic step(input logic wdv, input logic [31:0] wd, input logic hold);
        logic        room;
        logic [31:0] w;
        bus.WriteData      = wd;
        bus.WriteDataValid = wdv;
        bus.Hold           = hold;
        room = (m_fifo.size() != DEPTH);
        m_dv = 1'b0;
        if (!hold) begin
            if (m_cur.size() != 0) begin
                m_data = m_cur.pop_front();
                m_dv   = 1'b1;
            end else if (m_fifo.size() != 0) begin
                w = m_fifo.pop_front();
                m_data = w[31:24];
                m_cur.push_back(w[23:16]);
                m_cur.push_back(w[15:8]);
                m_cur.push_back(w[7:0]);
                m_dv = 1'b1;
            end
        end
        if (wdv) begin
            if (room) m_fifo.push_back(wd);
            else      m_ovf = 1'b1;
        end
        @(posedge Clk);
        #1;
        check("data_valid", 32'(bus.DataValid), 32'(m_dv));
        if (m_dv) check("data", 32'(bus.Data), 32'(m_data));
        check("level", 32'(bus.Level), 32'(m_fifo.size()));
        check("ready", 32'(bus.Ready), 32'(m_fifo.size() != DEPTH));
        check("overflow", 32'(bus.Overflow), 32'(m_ovf));
        if (bus.DataValid) got.push_back(bus.Data);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"}, 32'(bus.Data), 32'h00);
        check({tag, "_dv"}, 32'(bus.DataValid), 32'h0);
        check({tag, "_level"}, 32'(bus.Level), 32'h0);
        check({tag, "_ovf"}, 32'(bus.Overflow), 32'h0);
        check({tag, "_ready"}, 32'(bus.Ready), 32'h1);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
        check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(tag, 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [7:0] exp[$];
        bus.WriteData      = '0;
        bus.WriteDataValid = 1'b0;
        bus.Hold           = 1'b0;
        model_reset();

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        ARstn = 1'b1;
        #1;
        check_reset_values("reset");

        // single word
        got.delete();
        step(1'b1, 32'hDEADBEEF, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b0);
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_bytes("single", exp);

        // back-to-back words, gap-free
        got.delete();
        step(1'b1, 32'h01234567, 1'b0);
        step(1'b1, 32'h89ABCDEF, 1'b0);
        repeat (9) step(1'b0, 32'h0, 1'b0);
        exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        check_bytes("b2b", exp);

        // stall after byte AD
        got.delete();
        step(1'b1, 32'hDEADBEEF, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_bytes("stall", exp);

        // overflow while held
        got.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'(i), 1'b1);
            if (i == 3) begin
                check("full_ready", 32'(bus.Ready), 32'h0);
                check("full_level", 32'(bus.Level), 32'h4);
            end
        end
        check("ovf_set", 32'(bus.Overflow), 32'h1);
        repeat (20) step(1'b0, 32'h0, 1'b0);
        exp.delete();
        for (int i = 0; i < 4; i++) begin
            exp.push_back(8'h00); exp.push_back(8'h00);
            exp.push_back(8'h00); exp.push_back(8'(i));
        end
        check_bytes("ovf_bytes", exp);
        check("ovf_sticky", 32'(bus.Overflow), 32'h1);

        // randomized traffic with random stalls
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 25));
        repeat (24) step(1'b0, 32'h0, 1'b0);

        // reset mid-word with two words queued
        got.delete();
        step(1'b1, 32'hA1A2A3A4, 1'b0);
        step(1'b1, 32'hB1B2B3B4, 1'b0);
        step(1'b1, 32'hC1C2C3C4, 1'b0);
        check("pre_rst_level", 32'(bus.Level), 32'h2);
        #2;
        ARstn = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        bus.WriteDataValid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        ARstn = 1'b1;
        got.delete();
        repeat (8) step(1'b0, 32'h0, 1'b0);
        check("midrst_nobytes", 32'(got.size()), 32'h0);
        check("midrst_level", 32'(bus.Level), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
